if_id_pipe: RTL

Parametrised IF/ID pipeline register for the RISC-V core, carrying the fetched instruction, its PC and the `writeReg`/`signaltoReg` control bits from fetch to decode. It adds a valid/ready handshake with a one-entry skid buffer, so the stage runs at full throughput under back-pressure. It also provides a flush input that squashes in-flight beats and presents a NOP bubble to decode. It sits between the fetch unit and the decode/register-file stage.

---
 rtl/if_id_pipe_pkg.sv | 11 +
 rtl/pipe_slot.sv | 17 +
 rtl/if_id_pipe.sv | 86 ++++++++
 3 files changed

// File: rtl/if_id_pipe_pkg.sv
// if_id_pipe_pkg: shared IF/ID pipeline types and constants.
package if_id_pipe_pkg;
   localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;
   typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;
   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        write_reg;
      logic        signal_to_reg;
   } payload_t;
endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: payload register with load enable and async active-low clear.
module pipe_slot #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         ld,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   logic [W-1:0] data_q, data_d;
   always_comb data_d = ld ? d : data_q;
   always_ff @(posedge clk or negedge reset)
      if (!reset) data_q <= '0;
      else        data_q <= data_d;
   assign q = data_q;
endmodule

// File: rtl/if_id_pipe.sv
// if_id_pipe: IF/ID register with valid/ready handshake, one-entry skid buffer,
// flush to a NOP bubble.
module if_id_pipe
   import if_id_pipe_pkg::*;
#(
   parameter int          INSTR_W   = 32,
   parameter int          PC_W      = 32,
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [INSTR_W-1:0] in_instr,
   input  logic [PC_W-1:0]    in_pc,
   input  logic               in_write_reg,
   input  logic               in_signal_to_reg,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] out_instr,
   output logic [PC_W-1:0]    out_pc,
   output logic               out_write_reg,
   output logic               out_signal_to_reg
);
   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [PC_W-1:0]    pc;
      logic               write_reg;
      logic               signal_to_reg;
   } slot_t;
   localparam int SLOT_W = $bits(slot_t);
   state_t state_q, state_d;
   logic   in_ready_q, in_ready_d;
   slot_t  in_beat, main_q, main_d, skid_q;
   logic   main_ld, skid_ld, accept, consume;
   assign in_beat = {in_instr, in_pc, in_write_reg, in_signal_to_reg};
   always_comb begin
      accept     = in_valid & in_ready_q;
      consume    = (state_q != EMPTY) & out_ready;
      state_d    = state_q;
      main_ld    = 1'b0;
      skid_ld    = 1'b0;
      main_d     = in_beat;
      if (flush) state_d = EMPTY;
      else case (state_q)
         EMPTY: if (accept) begin
            state_d = FULL;
            main_ld = 1'b1;
         end
         FULL: if (accept) begin
            state_d = consume ? FULL : SKID;
            main_ld = consume;
            skid_ld = !consume;
         end else if (consume) state_d = EMPTY;
         SKID: if (consume) begin
            state_d = FULL;
            main_ld = 1'b1;
            main_d  = skid_q;
         end
         default: state_d = EMPTY;
      endcase
      // Registered ready: depends only on next state, never on out_ready combinationally.
      in_ready_d = state_d != SKID;
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state_q    <= EMPTY;
         in_ready_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         in_ready_q <= in_ready_d;
      end
   pipe_slot #(.W(SLOT_W)) u_main (
      .clk(clk), .reset(reset), .ld(main_ld), .d(main_d), .q(main_q)
   );
   pipe_slot #(.W(SLOT_W)) u_skid (
      .clk(clk), .reset(reset), .ld(skid_ld), .d(in_beat), .q(skid_q)
   );
   assign in_ready          = in_ready_q;
   assign out_valid         = state_q != EMPTY;
   assign out_instr         = out_valid ? main_q.instr : INSTR_W'(NOP_INSTR);
   assign out_pc            = main_q.pc;
   assign out_write_reg     = out_valid & main_q.write_reg;
   assign out_signal_to_reg = out_valid & main_q.signal_to_reg;
endmodule
